fifo_to_uart_controller: RTL and testbench
==========================================

Name: fifo_to_uart_controller

Overview:
- Readout sequencer for the logic analyzer. While the trigger block fills the sample FIFO, this block holds the UART idle.
- When the FIFO reports full, it masks the trigger block and reads the FIFO word by word. It sends each word as NUM_BYTES UART bytes, selected through the bit padder.
- When the FIFO is empty and the last byte has gone out, it resets the trigger block and re-arms capture.

Parameters:
- NUM_BYTES, 4, UART bytes per FIFO word (legal range 1..4); Bit_Padder_Sel counts 0..NUM_BYTES-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- FIFO_wrfull  in  1  FIFO full flag; starts a readout.
- FIFO_rdempty  in  1  FIFO empty flag; ends a readout.
- UART_txempty  in  1  1 = UART transmitter idle and ready for a byte.
- FIFO_rdreq  out  1  one-cycle FIFO read strobe.
- UART_rst  out  1  holds the UART in reset.
- UART_ld_tx_data  out  1  one-cycle load strobe for the UART tx register.
- UART_tx_enable  out  1  UART transmit enable.
- triggerBlock_Syncrst  out  1  synchronous reset to the trigger block.
- triggerBlock_Mask  out  3  trigger block mask: 3'b000 = capture enabled, 3'b111 = capture and trigger blocked.
- Bit_Padder_Sel  out  2  byte-slice select of the current FIFO word.
- state_debug  out  5  current state code, zero-extended.

Behaviour:
- Moore FSM. Outputs are decoded only from the registered state and the registered byte counter.
- Async rst forces state S_INIT and byte counter 0, from any state including mid-readout.
- Reset output values: Syncrst=1, UART_rst=1, Mask=3'b111, rdreq=0, ld=0, tx_enable=0, Sel=0, state_debug=0.
- States, with code and outputs (outputs not listed are 0):
  - S_INIT (0): Syncrst=1, UART_rst=1, Mask=111, counter cleared. Unconditionally goes to S_CAPTURE after 1 cycle.
  - S_CAPTURE (1): UART_rst=1, Mask=000. Goes to S_RDREQ when FIFO_wrfull=1; otherwise stays.
  - S_RDREQ (2): FIFO_rdreq=1 for exactly 1 cycle, counter cleared. Goes to S_RDWAIT.
  - S_RDWAIT (3): 1-cycle FIFO read latency. Goes to S_TXWAIT.
  - S_TXWAIT (4): waits for UART_txempty=1, then goes to S_LOAD.
  - S_LOAD (5): UART_ld_tx_data=1 for exactly 1 cycle. Goes to S_TXBUSY.
  - S_TXBUSY (6): waits for UART_txempty=0, meaning the byte was accepted. Then:
    - if counter < NUM_BYTES-1: counter+1, go to S_TXWAIT;
    - else if FIFO_rdempty=1: go to S_DRAIN;
    - else: go to S_RDREQ.
  - S_DRAIN (7): waits for UART_txempty=1 (last byte finished), then goes to S_INIT.
- In S_RDREQ through S_DRAIN: Mask=111, UART_tx_enable=1, UART_rst=0.
- Bit_Padder_Sel equals the counter. It is stable from S_RDWAIT through the end of the byte and changes only on the TXBUSY exit.
- FIFO_wrfull is ignored outside S_CAPTURE. FIFO_wrfull dropping mid-readout does not abort the readout.
- FIFO_rdempty is sampled only on the last byte's S_TXBUSY exit.
- Each load waits for a full txempty 1->0 handshake, so at most one ld pulse occurs per byte. No timeout: the FSM waits indefinitely on the UART.
- Latency: FIFO_wrfull=1 seen in S_CAPTURE at edge k gives rdreq high in cycle k+1 and the first ld in cycle k+4, provided txempty=1.

Decomposition:
- Shared package holds:
  - state localparams (5-bit codes 0..7);
  - MASK_CAPTURE=3'b000 and MASK_BLOCK=3'b111.
- Single module containing the state register, the 2-bit byte counter and output decode. No sub-module.

Test Plan:
- Reset: rst=1 for 1.5 cycles -> Syncrst=1, UART_rst=1, Mask=111, rdreq=0, ld=0, state_debug=0. After release: 1 cycle in S_INIT, then state_debug=1, Mask=000, UART_rst=1.
- Start: FIFO_wrfull=1, txempty=1 -> rdreq=1 for one cycle, then ld=1 for one cycle with Sel=0, tx_enable=1, Mask=111.
- Byte sequencing: bench drops txempty on each ld, holds it 0 for 12 cycles, then raises it -> ld pulses with Sel=0,1,2,3, then another rdreq and Sel=0 again. No second ld while txempty=0.
- Mid-readout wrfull drop: FIFO_wrfull=0 during bytes -> readout continues; ld still follows every txempty=1.
- End of dump: FIFO_rdempty=1 before the Sel=3 byte is accepted -> state 7 until txempty=1, then Syncrst=1 for one cycle (state 0), then state 1 with Mask=000, UART_rst=1.
- Async reset in S_TXBUSY: rst pulsed -> outputs immediately take reset values and Sel=0; no further ld or rdreq pulses.

Source files
------------

// File: rtl/fifo_to_uart_controller_pkg.sv
// Shared definitions for the logic-analyzer readout sequencer:
// state codes, trigger-block mask values and a small state classifier.
package fifo_to_uart_controller_pkg;

    localparam logic [4:0] S_INIT    = 5'd0;
    localparam logic [4:0] S_CAPTURE = 5'd1;
    localparam logic [4:0] S_RDREQ   = 5'd2;
    localparam logic [4:0] S_RDWAIT  = 5'd3;
    localparam logic [4:0] S_TXWAIT  = 5'd4;
    localparam logic [4:0] S_LOAD    = 5'd5;
    localparam logic [4:0] S_TXBUSY  = 5'd6;
    localparam logic [4:0] S_DRAIN   = 5'd7;

    localparam logic [2:0] MASK_CAPTURE = 3'b000;
    localparam logic [2:0] MASK_BLOCK   = 3'b111;

    // True for every state in which the FIFO is being dumped over the UART.
    function automatic logic is_readout(input logic [4:0] st);
        return (st >= S_RDREQ) && (st <= S_DRAIN);
    endfunction

endpackage

// File: rtl/fifo_to_uart_controller.sv
// Readout sequencer: holds the UART idle while the sample FIFO fills, then
// dumps each FIFO word as NUM_BYTES UART bytes and re-arms capture.
module fifo_to_uart_controller
    import fifo_to_uart_controller_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       FIFO_wrfull,
    input  logic       FIFO_rdempty,
    input  logic       UART_txempty,
    output logic       FIFO_rdreq,
    output logic       UART_rst,
    output logic       UART_ld_tx_data,
    output logic       UART_tx_enable,
    output logic       triggerBlock_Syncrst,
    output logic [2:0] triggerBlock_Mask,
    output logic [1:0] Bit_Padder_Sel,
    output logic [4:0] state_debug
);

    localparam logic [1:0] LAST_BYTE = 2'(NUM_BYTES - 1);

    logic [4:0] state_r;
    logic [4:0] state_s;
    logic [1:0] byte_cnt_r;
    logic [1:0] byte_cnt_s;

    // State and byte-counter registers; reset may land mid-readout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_INIT;
            byte_cnt_r <= 2'd0;
        end else begin
            state_r    <= state_s;
            byte_cnt_r <= byte_cnt_s;
        end
    end

    // Next-state and next-counter logic; the counter is cleared on entry to
    // INIT/RDREQ so the byte select reads 0 at the start of every word.
    always_comb begin
        state_s    = state_r;
        byte_cnt_s = byte_cnt_r;
        case (state_r)
            S_INIT: begin
                state_s    = S_CAPTURE;
                byte_cnt_s = 2'd0;
            end
            S_CAPTURE: begin
                if (FIFO_wrfull) begin
                    state_s = S_RDREQ;
                end else begin
                    state_s = S_CAPTURE;
                end
            end
            S_RDREQ: begin
                state_s    = S_RDWAIT;
                byte_cnt_s = 2'd0;
            end
            S_RDWAIT: begin
                state_s = S_TXWAIT;
            end
            S_TXWAIT: begin
                if (UART_txempty) begin
                    state_s = S_LOAD;
                end else begin
                    state_s = S_TXWAIT;
                end
            end
            S_LOAD: begin
                state_s = S_TXBUSY;
            end
            S_TXBUSY: begin
                // txempty falling means the UART took the byte.
                if (!UART_txempty) begin
                    if (byte_cnt_r < LAST_BYTE) begin
                        byte_cnt_s = byte_cnt_r + 2'd1;
                        state_s    = S_TXWAIT;
                    end else if (FIFO_rdempty) begin
                        state_s = S_DRAIN;
                    end else begin
                        byte_cnt_s = 2'd0;
                        state_s    = S_RDREQ;
                    end
                end else begin
                    state_s = S_TXBUSY;
                end
            end
            S_DRAIN: begin
                if (UART_txempty) begin
                    state_s    = S_INIT;
                    byte_cnt_s = 2'd0;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            default: begin
                state_s    = S_INIT;
                byte_cnt_s = 2'd0;
            end
        endcase
    end

    // Moore output decode from the registered state and counter only.
    always_comb begin
        FIFO_rdreq           = 1'b0;
        UART_ld_tx_data      = 1'b0;
        triggerBlock_Syncrst = 1'b0;
        UART_rst             = 1'b0;
        triggerBlock_Mask    = MASK_BLOCK;
        UART_tx_enable       = is_readout(state_r);
        Bit_Padder_Sel       = byte_cnt_r;
        state_debug          = state_r;
        case (state_r)
            S_INIT: begin
                triggerBlock_Syncrst = 1'b1;
                UART_rst             = 1'b1;
            end
            S_CAPTURE: begin
                UART_rst          = 1'b1;
                triggerBlock_Mask = MASK_CAPTURE;
            end
            S_RDREQ: begin
                FIFO_rdreq = 1'b1;
            end
            S_LOAD: begin
                UART_ld_tx_data = 1'b1;
            end
            default: begin
                FIFO_rdreq = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_to_uart_controller.sv
// Self-checking bench for fifo_to_uart_controller: a procedural readout model
// plus a small UART responder and directed scenario checks.
module tb_fifo_to_uart_controller;

    localparam int NB = 4;

    logic clk          = 1'b0;
    logic rst          = 1'b1;
    logic FIFO_wrfull  = 1'b0;
    logic FIFO_rdempty = 1'b0;
    logic UART_txempty = 1'b1;

    logic       FIFO_rdreq;
    logic       UART_rst;
    logic       UART_ld_tx_data;
    logic       UART_tx_enable;
    logic       triggerBlock_Syncrst;
    logic [2:0] triggerBlock_Mask;
    logic [1:0] Bit_Padder_Sel;
    logic [4:0] state_debug;

    fifo_to_uart_controller #(.NUM_BYTES(NB)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .FIFO_wrfull          (FIFO_wrfull),
        .FIFO_rdempty         (FIFO_rdempty),
        .UART_txempty         (UART_txempty),
        .FIFO_rdreq           (FIFO_rdreq),
        .UART_rst             (UART_rst),
        .UART_ld_tx_data      (UART_ld_tx_data),
        .UART_tx_enable       (UART_tx_enable),
        .triggerBlock_Syncrst (triggerBlock_Syncrst),
        .triggerBlock_Mask    (triggerBlock_Mask),
        .Bit_Padder_Sel       (Bit_Padder_Sel),
        .state_debug          (state_debug)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- expected outputs, filled by the model ----------------
    logic [4:0] exp_state;
    logic [1:0] exp_sel;
    logic       exp_syncrst, exp_uart_rst, exp_txen, exp_rdreq, exp_ld;
    logic [2:0] exp_mask;

    // Output table of each phase of the readout sequence.
    task automatic expect_phase(input int code, input int sel);
        exp_state    = 5'(code);
        exp_sel      = 2'(sel);
        exp_syncrst  = (code == 0);
        exp_uart_rst = (code <= 1);
        exp_mask     = (code == 1) ? 3'b000 : 3'b111;
        exp_txen     = (code >= 2);
        exp_rdreq    = (code == 2);
        exp_ld       = (code == 5);
    endtask

    bit ab;
    task automatic tick();
        @(posedge clk or posedge rst);
        ab = rst;
    endtask

    // One capture/readout pass written as a sequential procedure.
    task automatic model_run();
        expect_phase(0, 0);
        tick(); if (ab) return;
        expect_phase(1, 0);
        do begin tick(); if (ab) return; end while (!FIFO_wrfull);
        forever begin
            expect_phase(2, 0);
            tick(); if (ab) return;
            expect_phase(3, 0);
            tick(); if (ab) return;
            for (int b = 0; b < NB; b++) begin
                expect_phase(4, b);
                do begin tick(); if (ab) return; end while (!UART_txempty);
                expect_phase(5, b);
                tick(); if (ab) return;
                expect_phase(6, b);
                do begin tick(); if (ab) return; end while (UART_txempty);
            end
            if (FIFO_rdempty) begin
                expect_phase(7, NB - 1);
                do begin tick(); if (ab) return; end while (!UART_txempty);
                return;
            end
        end
    endtask

    initial begin : model
        forever begin
            expect_phase(0, 0);
            if (rst) wait (!rst);
            ab = 1'b0;
            model_run();
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        chk("state_debug", 32'(state_debug), 32'(exp_state));
        chk("Bit_Padder_Sel", 32'(Bit_Padder_Sel), 32'(exp_sel));
        chk("Syncrst", 32'(triggerBlock_Syncrst), 32'(exp_syncrst));
        chk("UART_rst", 32'(UART_rst), 32'(exp_uart_rst));
        chk("Mask", 32'(triggerBlock_Mask), 32'(exp_mask));
        chk("tx_enable", 32'(UART_tx_enable), 32'(exp_txen));
        chk("rdreq", 32'(FIFO_rdreq), 32'(exp_rdreq));
        chk("ld", 32'(UART_ld_tx_data), 32'(exp_ld));
    end

    // ---------------- pulse monitor and UART responder ----------------
    int ld_cnt = 0;
    int rdreq_cnt = 0;
    int extra_ld = 0;
    int hold = 0;
    logic [1:0] sel_log[$];

    // Record every strobe and the byte select carried with each load.
    always @(negedge clk) begin
        if (UART_ld_tx_data) begin
            ld_cnt++;
            sel_log.push_back(Bit_Padder_Sel);
        end
        if (FIFO_rdreq) rdreq_cnt++;
    end

    // UART stand-in: busy for 12 cycles after each accepted load.
    always @(negedge clk) begin
        if (UART_ld_tx_data) begin
            if (!UART_txempty) extra_ld++;
            UART_txempty = 1'b0;
            hold = 12;
        end else if (hold > 0) begin
            hold--;
            if (hold == 0) UART_txempty = 1'b1;
        end
    end

    // ---------------- directed scenario ----------------
    int first_rdreq, first_ld, snap_ld, snap_rdreq;
    logic [1:0] exp_seq [4] = '{2'd0, 2'd1, 2'd2, 2'd3};

    initial begin
        // Reset values while rst is held.
        @(negedge clk);
        chk("rst_state", 32'(state_debug), 32'd0);
        chk("rst_syncrst", 32'(triggerBlock_Syncrst), 32'd1);
        chk("rst_uart_rst", 32'(UART_rst), 32'd1);
        chk("rst_mask", 32'(triggerBlock_Mask), 32'h7);
        chk("rst_rdreq", 32'(FIFO_rdreq), 32'd0);
        chk("rst_ld", 32'(UART_ld_tx_data), 32'd0);
        #6 rst = 1'b0;
        @(negedge clk);
        chk("init_cycle_state", 32'(state_debug), 32'd0);
        @(negedge clk);
        chk("capture_state", 32'(state_debug), 32'd1);
        chk("capture_mask", 32'(triggerBlock_Mask), 32'h0);
        chk("capture_uart_rst", 32'(UART_rst), 32'd1);

        // Start a readout and measure strobe latency.
        FIFO_wrfull = 1'b1;
        first_rdreq = 0;
        first_ld    = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (FIFO_rdreq && first_rdreq == 0) first_rdreq = n;
            if (UART_ld_tx_data && first_ld == 0) first_ld = n;
        end
        chk("rdreq_latency", 32'(first_rdreq), 32'd1);
        chk("ld_latency", 32'(first_ld), 32'd4);
        FIFO_wrfull = 1'b0;

        // First word completes despite wrfull dropping; second word starts.
        for (int i = 0; i < 400 && rdreq_cnt < 2; i++) @(negedge clk);
        chk("second_rdreq", 32'(rdreq_cnt), 32'd2);
        chk("word1_ld_count", 32'(ld_cnt), 32'd4);
        for (int i = 0; i < 4; i++) chk("word1_sel", 32'(sel_log[i]), 32'(exp_seq[i]));
        FIFO_rdempty = 1'b1;

        // Last word then drain.
        for (int i = 0; i < 400 && state_debug != 5'd7; i++) @(negedge clk);
        chk("drain_reached", 32'(state_debug), 32'd7);
        chk("word2_ld_count", 32'(ld_cnt), 32'd8);
        for (int i = 0; i < 4; i++) chk("word2_sel", 32'(sel_log[4 + i]), 32'(exp_seq[i]));
        for (int i = 0; i < 40 && state_debug != 5'd0; i++) @(negedge clk);
        chk("rearm_init", 32'(state_debug), 32'd0);
        chk("rearm_syncrst", 32'(triggerBlock_Syncrst), 32'd1);
        @(negedge clk);
        chk("rearm_capture", 32'(state_debug), 32'd1);
        chk("rearm_mask", 32'(triggerBlock_Mask), 32'h0);
        chk("rearm_uart_rst", 32'(UART_rst), 32'd1);
        FIFO_rdempty = 1'b0;

        // Async reset in the middle of a byte handshake.
        FIFO_wrfull = 1'b1;
        for (int i = 0; i < 100 && state_debug != 5'd6; i++) @(negedge clk);
        chk("txbusy_reached", 32'(state_debug), 32'd6);
        #2 rst = 1'b1;
        #1;
        chk("async_state", 32'(state_debug), 32'd0);
        chk("async_sel", 32'(Bit_Padder_Sel), 32'd0);
        chk("async_syncrst", 32'(triggerBlock_Syncrst), 32'd1);
        chk("async_mask", 32'(triggerBlock_Mask), 32'h7);
        chk("async_txen", 32'(UART_tx_enable), 32'd0);
        @(negedge clk);
        @(negedge clk);
        FIFO_wrfull = 1'b0;
        #2 rst = 1'b0;
        snap_ld    = ld_cnt;
        snap_rdreq = rdreq_cnt;
        repeat (30) @(negedge clk);
        chk("post_reset_no_ld", 32'(ld_cnt), 32'(snap_ld));
        chk("post_reset_no_rdreq", 32'(rdreq_cnt), 32'(snap_rdreq));
        chk("post_reset_capture", 32'(state_debug), 32'd1);
        chk("no_ld_while_busy", 32'(extra_ld), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
